// File: rtl/pingpong_ball_engine_pkg.sv
// Shared definitions for the ping-pong ball engine and its next-state logic:
// game state encodings, serve positions/directions and field/timer limits.
package pingpong_ball_engine_pkg;

   typedef enum logic [1:0] {
      P1_SERVE = 2'd0,
      P2_SERVE = 2'd1,
      PLAYING  = 2'd2,
      GAME_END = 2'd3
   } game_state_t;

   typedef enum logic {
      AXIS_SATURATE = 1'b0,
      AXIS_REFLECT  = 1'b1
   } axis_mode_t;

   localparam logic [2:0] FIELD_MAX = 3'd7;
   localparam logic [5:0] TIME_INIT = 6'd60;

   localparam logic [2:0] P1_SERVE_X  = 3'd0;
   localparam logic [2:0] P1_SERVE_Y  = 3'd3;
   localparam logic       P1_SERVE_DX = 1'b1;
   localparam logic       P1_SERVE_DY = 1'b1;

   localparam logic [2:0] P2_SERVE_X  = 3'd7;
   localparam logic [2:0] P2_SERVE_Y  = 3'd4;
   localparam logic       P2_SERVE_DX = 1'b0;
   localparam logic       P2_SERVE_DY = 1'b0;

endpackage

// File: rtl/pingpong_ball_engine_axis.sv
// One axis of ball motion: 3-bit position plus direction, with load, step,
// direction toggle and either wall reflection or end saturation.
module pingpong_axis
   import pingpong_ball_engine_pkg::*;
#(
   parameter axis_mode_t MODE      = AXIS_SATURATE,
   parameter logic [2:0] RESET_POS = 3'd0,
   parameter logic       RESET_DIR = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [2:0] load_pos,
   input  logic       load_dir,
   input  logic       step,
   input  logic       toggle,
   output logic [2:0] pos,
   output logic       dir
);

   logic [2:0] pos_next;
   logic       dir_next;
   logic       eff_dir;

   // A toggle coinciding with a step takes effect before the move.
   assign eff_dir = dir ^ toggle;

   always_comb begin
      pos_next = pos;
      dir_next = eff_dir;
      if (step) begin
         if (eff_dir && pos == FIELD_MAX) begin
            if (MODE == AXIS_REFLECT) begin
               dir_next = 1'b0;
               pos_next = FIELD_MAX - 3'd1;
            end
         end else if (!eff_dir && pos == 3'd0) begin
            if (MODE == AXIS_REFLECT) begin
               dir_next = 1'b1;
               pos_next = 3'd1;
            end
         end else if (eff_dir) begin
            pos_next = pos + 3'd1;
         end else begin
            pos_next = pos - 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos <= RESET_POS;
         dir <= RESET_DIR;
      end else if (load) begin
         pos <= load_pos;
         dir <= load_dir;
      end else begin
         pos <= pos_next;
         dir <= dir_next;
      end
   end

endmodule

// File: rtl/pingpong_ball_engine.sv
// Ping-pong ball engine: registers the game state, moves the ball on the
// 8x8 field and counts down the match timer.
module pingpong_ball_engine
   import pingpong_ball_engine_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       step,
   input  logic       sec_tick,
   input  logic       reverse_x,
   input  logic [1:0] game_next_state,
   output logic [1:0] game_state,
   output logic [2:0] ball_x,
   output logic [2:0] ball_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic [5:0] time_cnt
);

   game_state_t state;
   logic        serving;
   logic        playing;
   logic [2:0]  serve_x;
   logic [2:0]  serve_y;
   logic        serve_dx;
   logic        serve_dy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= P1_SERVE;
      end else begin
         state <= game_state_t'(game_next_state);
      end
   end

   assign game_state = state;

   // Ball control is decoded from the pre-edge state, so the edge that
   // enters PLAYING does not move the ball.
   always_comb begin
      serving  = (state == P1_SERVE) || (state == P2_SERVE);
      playing  = (state == PLAYING);
      serve_x  = P1_SERVE_X;
      serve_y  = P1_SERVE_Y;
      serve_dx = P1_SERVE_DX;
      serve_dy = P1_SERVE_DY;
      if (state == P2_SERVE) begin
         serve_x  = P2_SERVE_X;
         serve_y  = P2_SERVE_Y;
         serve_dx = P2_SERVE_DX;
         serve_dy = P2_SERVE_DY;
      end
   end

   pingpong_axis #(
      .MODE      (AXIS_SATURATE),
      .RESET_POS (P1_SERVE_X),
      .RESET_DIR (P1_SERVE_DX)
   ) u_axis_x (
      .clk      (clk),
      .reset    (reset),
      .load     (serving),
      .load_pos (serve_x),
      .load_dir (serve_dx),
      .step     (playing && step),
      .toggle   (playing && reverse_x),
      .pos      (ball_x),
      .dir      (dir_x)
   );

   pingpong_axis #(
      .MODE      (AXIS_REFLECT),
      .RESET_POS (P1_SERVE_Y),
      .RESET_DIR (P1_SERVE_DY)
   ) u_axis_y (
      .clk      (clk),
      .reset    (reset),
      .load     (serving),
      .load_pos (serve_y),
      .load_dir (serve_dy),
      .step     (playing && step),
      .toggle   (1'b0),
      .pos      (ball_y),
      .dir      (dir_y)
   );

   // Match time is never reloaded by serves or points, only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         time_cnt <= TIME_INIT;
      end else if (sec_tick && state != GAME_END && time_cnt != 6'd0) begin
         time_cnt <= time_cnt - 6'd1;
      end
   end

endmodule

// File: tb/tb_pingpong_ball_engine.sv
// Directed vector bench for pingpong_ball_engine: a table of per-cycle
// inputs and expected outputs, plus timer and END-state sequences.
module tb_pingpong_ball_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       step = 1'b0;
   logic       sec_tick = 1'b0;
   logic       reverse_x = 1'b0;
   logic [1:0] game_next_state = 2'd0;
   logic [1:0] game_state;
   logic [2:0] ball_x;
   logic [2:0] ball_y;
   logic       dir_x;
   logic       dir_y;
   logic [5:0] time_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pingpong_ball_engine dut (
      .clk             (clk),
      .reset           (reset),
      .step            (step),
      .sec_tick        (sec_tick),
      .reverse_x       (reverse_x),
      .game_next_state (game_next_state),
      .game_state      (game_state),
      .ball_x          (ball_x),
      .ball_y          (ball_y),
      .dir_x           (dir_x),
      .dir_y           (dir_y),
      .time_cnt        (time_cnt)
   );

   typedef struct packed {
      logic       rst;
      logic       stp;
      logic       tck;
      logic       rev;
      logic [1:0] nxt;
      logic [1:0] st;
      logic [2:0] x;
      logic [2:0] y;
      logic       dx;
      logic       dy;
      logic [5:0] t;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic stp, input logic tck,
                               input logic rev, input logic [1:0] nxt,
                               input logic [1:0] st, input logic [2:0] x,
                               input logic [2:0] y, input logic dx,
                               input logic dy, input logic [5:0] t);
      vec_t v;
      v.rst = rst; v.stp = stp; v.tck = tck; v.rev = rev; v.nxt = nxt;
      v.st = st; v.x = x; v.y = y; v.dx = dx; v.dy = dy; v.t = t;
      return v;
   endfunction

   task automatic drive(input logic rst, input logic stp, input logic tck,
                        input logic rev, input logic [1:0] nxt);
      reset = rst; step = stp; sec_tick = tck; reverse_x = rev;
      game_next_state = nxt;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all(input string name, input logic [1:0] st,
                            input logic [2:0] x, input logic [2:0] y,
                            input logic dx, input logic dy, input logic [5:0] t);
      logic [15:0] got;
      logic [15:0] exp;
      got = {game_state, ball_x, ball_y, dir_x, dir_y, time_cnt};
      exp = {st, x, y, dx, dy, t};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got st=%0d x=%0d y=%0d dx=%0d dy=%0d t=%0d, expected st=%0d x=%0d y=%0d dx=%0d dy=%0d t=%0d",
                  name, game_state, ball_x, ball_y, dir_x, dir_y, time_cnt,
                  st, x, y, dx, dy, t);
      end
   endtask

   task automatic check_time(input string name, input logic [5:0] t);
      checks++;
      if (time_cnt !== t) begin
         errors++;
         $display("FAIL %s: time_cnt=%0d expected %0d", name, time_cnt, t);
      end
   endtask

   initial begin
      //                  rst stp tck rev nxt    st  x  y dx dy  t
      vecs.push_back(mk(1, 0, 0, 0, 2'd0, 2'd0, 0, 3, 1, 1, 60));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 0, 0, 0, 2'd0, 2'd0, 0, 3, 1, 1, 60));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 0, 3, 1, 1, 60)); // entry edge: no move
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 1, 4, 1, 1, 60));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 2, 5, 1, 1, 60));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 3, 6, 1, 1, 60));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 4, 7, 1, 1, 60));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 5, 6, 1, 0, 60)); // top wall
      vecs.push_back(mk(0, 0, 1, 0, 2'd2, 2'd2, 5, 6, 1, 0, 59)); // hold, tick
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 6, 5, 1, 0, 59));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 7, 4, 1, 0, 59));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 7, 3, 1, 0, 59)); // x saturates at 7
      vecs.push_back(mk(0, 1, 0, 1, 2'd2, 2'd2, 6, 2, 0, 0, 59)); // toggle then move
      vecs.push_back(mk(0, 0, 0, 1, 2'd2, 2'd2, 6, 2, 1, 0, 59));
      vecs.push_back(mk(0, 0, 0, 1, 2'd2, 2'd2, 6, 2, 0, 0, 59));
      vecs.push_back(mk(0, 0, 0, 0, 2'd1, 2'd1, 6, 2, 0, 0, 59));
      vecs.push_back(mk(0, 1, 0, 1, 2'd1, 2'd1, 7, 4, 0, 0, 59)); // P2 serve load
      vecs.push_back(mk(0, 1, 1, 1, 2'd1, 2'd1, 7, 4, 0, 0, 58));
      vecs.push_back(mk(0, 0, 0, 0, 2'd2, 2'd2, 7, 4, 0, 0, 58));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 6, 3, 0, 0, 58));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 5, 2, 0, 0, 58));
      vecs.push_back(mk(1, 1, 1, 1, 2'd3, 2'd0, 0, 3, 1, 1, 60)); // reset wins
      vecs.push_back(mk(0, 0, 0, 0, 2'd3, 2'd3, 0, 3, 1, 1, 60));
      vecs.push_back(mk(0, 1, 1, 1, 2'd3, 2'd3, 0, 3, 1, 1, 60)); // END frozen
      vecs.push_back(mk(0, 0, 0, 0, 2'd0, 2'd0, 0, 3, 1, 1, 60));
      vecs.push_back(mk(0, 0, 1, 1, 2'd0, 2'd0, 0, 3, 1, 1, 59)); // tick in serve
      vecs.push_back(mk(0, 0, 0, 0, 2'd1, 2'd1, 0, 3, 1, 1, 59));
      vecs.push_back(mk(0, 0, 0, 0, 2'd2, 2'd2, 7, 4, 0, 0, 59));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 6, 3, 0, 0, 59));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 5, 2, 0, 0, 59));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 4, 1, 0, 0, 59));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 3, 0, 0, 0, 59));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 2, 1, 0, 1, 59)); // bottom wall
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 1, 2, 0, 1, 59));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 0, 3, 0, 1, 59));
      vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2'd2, 0, 4, 0, 1, 59)); // x saturates at 0

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].stp, vecs[i].tck, vecs[i].rev, vecs[i].nxt);
         check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].x, vecs[i].y,
                   vecs[i].dx, vecs[i].dy, vecs[i].t);
      end

      // Timer drains to zero in PLAYING and saturates there.
      drive(1, 0, 0, 0, 2'd0);
      drive(0, 0, 0, 0, 2'd2);
      for (int i = 1; i <= 61; i++) begin
         drive(0, 0, 1, 0, 2'd2);
         if (i == 30) check_time("timer_30", 6'd30);
         if (i == 59) check_time("timer_59", 6'd1);
         if (i == 60) check_time("timer_60", 6'd0);
      end
      check_time("timer_61", 6'd0);
      drive(0, 0, 0, 0, 2'd3);
      drive(0, 0, 1, 0, 2'd3);
      check_all("end_at_zero", 2'd3, 0, 3, 1, 1, 0);

      // Reset reloads the timer; END ignores sec_tick with time remaining.
      drive(1, 0, 1, 0, 2'd2);
      check_time("reset_reload", 6'd60);
      drive(0, 0, 1, 0, 2'd3);
      check_time("tick_in_serve", 6'd59);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 2'd3);
      check_all("end_hold_time", 2'd3, 0, 3, 1, 1, 59);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pingpong_ball_engine.md
PINGPONG_BALL_ENGINE -- requirements
Module: pingpong_ball_engine

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port step, input, 1, one-cycle pulse that advances the ball one cell.
REQ-004 SHALL have port sec_tick, input, 1, one-cycle pulse at 1 Hz for the match timer.
REQ-005 SHALL have port reverse_x, input, 1, one-cycle pulse from the next-state logic when a paddle returns the ball.
REQ-006 SHALL have port game_next_state, input, 2, next game state from the next-state logic.
REQ-007 SHALL have port game_state, output, 2, registered current state: 0 P1_SERVE, 1 P2_SERVE, 2 PLAYING, 3 END.
REQ-008 SHALL have ports ball_x and ball_y, output, 3 each, ball cell on the 8x8 field (x=0 is P1 side, x=7 is P2 side).
REQ-009 SHALL have ports dir_x and dir_y, output, 1 each, ball direction (1 = increasing, 0 = decreasing).
REQ-010 SHALL have port time_cnt, output, 6, remaining match seconds.

Function
REQ-011 SHALL register game_state <= game_next_state every cycle, giving 1-cycle latency.
REQ-012 In P1_SERVE, SHALL load ball_x=0, ball_y=3, dir_x=1, dir_y=1 every cycle, ignoring step and reverse_x.
REQ-013 In P2_SERVE, SHALL load ball_x=7, ball_y=4, dir_x=0, dir_y=0 every cycle, ignoring step and reverse_x.
REQ-014 In PLAYING, on step SHALL move ball_x by ±1 per dir_x and ball_y by ±1 per dir_y; without step the position SHALL hold.
REQ-015 Y wall reflect: on step with ball_y=7 and dir_y=1, SHALL set dir_y=0 and ball_y=6; with ball_y=0 and dir_y=0, SHALL set dir_y=1 and ball_y=1; no wrap-around.
REQ-016 X end saturate: on step with ball_x=7/dir_x=1 or ball_x=0/dir_x=0, ball_x SHALL hold, because miss detection belongs to the next-state logic.
REQ-017 In PLAYING, reverse_x SHALL toggle dir_x; if step coincides, SHALL apply the toggle first, then move with the new direction.
REQ-018 reverse_x outside PLAYING SHALL be ignored.
REQ-019 In END, ball position and directions SHALL freeze.
REQ-020 time_cnt SHALL decrement by 1 on sec_tick in every state except END, and SHALL saturate at 0.
REQ-021 time_cnt SHALL NOT reload on serve or point transitions; only reset reloads it.
REQ-022 Ball update on a cycle SHALL use the pre-edge game_state: the cycle that registers PLAYING moves nothing, and the first possible move is the following step.
REQ-023 All outputs SHALL be registers, with no combinational path from inputs to outputs.

Reset
REQ-024 With reset high at a clk edge, SHALL set game_state=0, ball_x=0, ball_y=3, dir_x=1, dir_y=1, time_cnt=60.
REQ-025 Reset SHALL take priority over step, sec_tick, reverse_x and game_next_state in the same cycle.
REQ-026 Reset mid-rally SHALL abandon motion immediately, with no residual direction or position.

Structure
REQ-027 A shared package SHALL hold the state encodings, serve positions/directions, FIELD_MAX=7 and TIME_INIT=60, also used by the next-state logic.
REQ-028 One sub-module, pingpong_axis, SHALL implement a 3-bit position/direction register with load, step, toggle and a reflect-or-saturate mode parameter; it SHALL be instantiated for x (saturate) and y (reflect).
REQ-029 Timer logic SHALL stay in the top module.

Verification
REQ-030 Reset, then hold game_next_state=0 for 5 cycles -> game_state=0, ball (0,3), dir (1,1), time_cnt=60.
REQ-031 Go to PLAYING, then 4 step pulses -> ball (4,7), dir_y=1; 5th step -> (5,6), dir_y=0.
REQ-032 PLAYING at ball_x=7, dir_x=1, step without reverse_x -> ball_x stays 7; step with reverse_x -> dir_x=0, ball_x=6.
REQ-033 61 sec_tick pulses in PLAYING -> time_cnt reaches 0 after 60 and stays 0; in END, sec_tick leaves time_cnt unchanged.
REQ-034 Mid-rally game_next_state=1 -> next cycle game_state=1; one cycle later ball (7,4), dir (0,0); step is ignored.
REQ-035 Reset asserted together with step and reverse_x at ball (5,2) -> reset values only, no move.
